// File: rtl/rd_ptr_sync_ctrl.sv
// Read-side pointer controller for the async FIFO: write-pointer synchroniser, binary/Gray read
// pointers, registered empty/level/almost-empty. Define RD_PTR_UNDERFLOW_EN for a sticky underflow flag.
module rd_ptr_sync_ctrl #(
   parameter int DEPTH       = 128,
   parameter int PTR_SIZE    = $clog2(DEPTH),
   parameter int SYNC_STAGES = 2,
   parameter int AE_THRESH   = 4
) (
   input  logic                rd_clk,
   input  logic                rd_reset,
   input  logic                rd_en,
   input  logic [PTR_SIZE:0]   g_wr_ptr,
   output logic                rd_fire,
   output logic [PTR_SIZE-1:0] rd_addr,
   output logic [PTR_SIZE:0]   b_rd_ptr,
   output logic [PTR_SIZE:0]   g_rd_ptr,
   output logic                empty,
   output logic                almost_empty,
   output logic [PTR_SIZE:0]   rd_level,
   output logic                underflow
);

   localparam logic [PTR_SIZE:0] AE_LIMIT = (PTR_SIZE+1)'(AE_THRESH);

   logic [PTR_SIZE:0] sync_q [SYNC_STAGES];
   logic [PTR_SIZE:0] wr_bin_s;
   logic [PTR_SIZE:0] b_next;
   logic [PTR_SIZE:0] g_next;
   logic [PTR_SIZE:0] level_next;

   // Handshake: ~empty is "valid", rd_en is "ready"; one entry is consumed in exactly the
   // cycles where both are high, and rd_fire marks those cycles (it is the RAM read strobe).
   assign rd_fire = rd_en & ~empty;
   assign rd_addr = b_rd_ptr[PTR_SIZE-1:0];

   always_ff @(posedge rd_clk) begin
      if (rd_reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= g_wr_ptr;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   // Bit i of the binary value is the XOR of all Gray bits at position i and above.
   always_comb begin
      wr_bin_s = '0;
      for (int i = 0; i <= PTR_SIZE; i++) wr_bin_s[i] = ^(sync_q[SYNC_STAGES-1] >> i);
   end

   assign b_next     = b_rd_ptr + {{PTR_SIZE{1'b0}}, rd_fire};
   assign g_next     = (b_next >> 1) ^ b_next;
   assign level_next = wr_bin_s - b_next;

   always_ff @(posedge rd_clk) begin
      if (rd_reset) begin
         b_rd_ptr     <= '0;
         g_rd_ptr     <= '0;
         empty        <= 1'b1;
         almost_empty <= 1'b1;
         rd_level     <= '0;
      end else begin
         b_rd_ptr     <= b_next;
         g_rd_ptr     <= g_next;
         empty        <= (b_next == wr_bin_s);
         almost_empty <= (level_next <= AE_LIMIT);
         rd_level     <= level_next;
      end
   end

`ifdef RD_PTR_UNDERFLOW_EN
   logic underflow_q;

   always_ff @(posedge rd_clk) begin
      if (rd_reset) begin
         underflow_q <= 1'b0;
      end else if (rd_en & empty) begin
         underflow_q <= 1'b1;
      end
   end

   assign underflow = underflow_q;
`else
   assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_rd_ptr_sync_ctrl.sv
// Bench for rd_ptr_sync_ctrl (DEPTH=8): directed scenarios plus randomized traffic against a
// count-based reference model of the read side.
module tb_rd_ptr_sync_ctrl;
   localparam int DEPTH = 8;
   localparam int PS    = 3;
   localparam int PW    = PS + 1;
   localparam int SYNC  = 2;
   localparam int AE    = 4;
`ifdef RD_PTR_UNDERFLOW_EN
   localparam bit UF_ON = 1'b1;
`else
   localparam bit UF_ON = 1'b0;
`endif

   logic          rd_clk;
   logic          rd_reset;
   logic          rd_en;
   logic [PW-1:0] g_wr_ptr;
   logic          rd_fire;
   logic [PS-1:0] rd_addr;
   logic [PW-1:0] b_rd_ptr;
   logic [PW-1:0] g_rd_ptr;
   logic          empty;
   logic          almost_empty;
   logic [PW-1:0] rd_level;
   logic          underflow;

   rd_ptr_sync_ctrl #(
      .DEPTH(DEPTH), .PTR_SIZE(PS), .SYNC_STAGES(SYNC), .AE_THRESH(AE)
   ) dut (
      .rd_clk(rd_clk), .rd_reset(rd_reset), .rd_en(rd_en), .g_wr_ptr(g_wr_ptr),
      .rd_fire(rd_fire), .rd_addr(rd_addr), .b_rd_ptr(b_rd_ptr), .g_rd_ptr(g_rd_ptr),
      .empty(empty), .almost_empty(almost_empty), .rd_level(rd_level), .underflow(underflow)
   );

   // clock / reset
   initial rd_clk = 1'b0;
   always #5 rd_clk = ~rd_clk;

   // reference model: writer and reader as unbounded entry counts
   int   wr_cnt;
   int   rd_cnt;
   int   hist[$];
   int   exp_level;
   bit   exp_empty;
   bit   exp_ae;
   bit   exp_uf;
   logic obs_fire;
   bit   pre_fire;
   int   checks;
   int   failures;

   function automatic logic [PW-1:0] gray(input int n);
      logic [PW-1:0] b;
      b = n[PW-1:0];
      return b ^ (b >> 1);
   endfunction

   // driver: one clock cycle, inputs driven away from the edge, model advanced at the edge
   task automatic step(input bit rst, input bit en);
      int vis;
      rd_reset = rst;
      rd_en    = en;
      g_wr_ptr = gray(wr_cnt);
      #1;
      obs_fire = rd_fire;
      pre_fire = en && !exp_empty;
      @(posedge rd_clk);
      if (rst) begin
         rd_cnt = 0;
         hist.delete();
         for (int i = 0; i < SYNC; i++) hist.push_back(0);
         exp_level = 0;
         exp_empty = 1'b1;
         exp_ae    = 1'b1;
         exp_uf    = 1'b0;
      end else begin
         if (UF_ON && en && exp_empty) exp_uf = 1'b1;
         if (pre_fire) rd_cnt++;
         vis = hist.pop_front();
         hist.push_back(wr_cnt);
         exp_level = vis - rd_cnt;
         exp_empty = (exp_level == 0);
         exp_ae    = (exp_level <= AE);
      end
      @(negedge rd_clk);
   endtask

   task automatic do_reset();
      wr_cnt = 0;
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0);
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({empty, almost_empty, rd_level, b_rd_ptr, g_rd_ptr, underflow} !== {1'b1, 1'b1, 4'd0, 4'd0, 4'd0, 1'b0}) begin
         failures++;
         $display("FAIL reset: got e=%b ae=%b lvl=%0d b=%0d g=%0d uf=%b, want e=1 ae=1 lvl=0 b=0 g=0 uf=0",
                  empty, almost_empty, rd_level, b_rd_ptr, g_rd_ptr, underflow);
      end
   endtask

   task automatic test_single_write();
      do_reset();
      wr_cnt = 1;
      for (int k = 0; k < 3; k++) begin
         step(1'b0, 1'b0);
         checks++;
         if (k < 2 && (empty !== 1'b1 || rd_level !== 4'd0)) begin
            failures++;
            $display("FAIL single_write_early edge k+%0d: got e=%b lvl=%0d, want e=1 lvl=0", k, empty, rd_level);
         end else if (k == 2 && (empty !== 1'b0 || rd_level !== 4'd1)) begin
            failures++;
            $display("FAIL single_write_visible: got e=%b lvl=%0d, want e=0 lvl=1", empty, rd_level);
         end
      end
   endtask

   task automatic test_drain();
      int fires;
      do_reset();
      wr_cnt = 5;
      idle(3);
      checks++;
      if (rd_level !== 4'd5) begin
         failures++;
         $display("FAIL drain_start: got lvl=%0d, want 5", rd_level);
      end
      fires = 0;
      for (int i = 0; i < 7; i++) begin
         step(1'b0, 1'b1);
         if (obs_fire === 1'b1) fires++;
         if (i < 5) begin
            checks++;
            if (rd_level !== 4'(4 - i)) begin
               failures++;
               $display("FAIL drain_level read %0d: got %0d, want %0d", i, rd_level, 4 - i);
            end
         end
      end
      checks++;
      if (fires != 5 || b_rd_ptr !== 4'd5 || empty !== 1'b1) begin
         failures++;
         $display("FAIL drain_end: got fires=%0d b=%0d e=%b, want fires=5 b=5 e=1", fires, b_rd_ptr, empty);
      end
   endtask

   task automatic test_wrap();
      int addr_seq[4];
      int b_seq[4];
      addr_seq = '{6, 7, 0, 1};
      b_seq    = '{15, 0, 1, 2};
      do_reset();
      wr_cnt = 7;  idle(3);
      for (int i = 0; i < 7; i++) step(1'b0, 1'b1);
      wr_cnt = 14; idle(3);
      for (int i = 0; i < 7; i++) step(1'b0, 1'b1);
      wr_cnt = 18; idle(3);
      checks++;
      if (b_rd_ptr !== 4'd14 || rd_level !== 4'd4) begin
         failures++;
         $display("FAIL wrap_start: got b=%0d lvl=%0d, want b=14 lvl=4", b_rd_ptr, rd_level);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (rd_addr !== 3'(addr_seq[i])) begin
            failures++;
            $display("FAIL wrap_addr %0d: got %0d, want %0d", i, rd_addr, addr_seq[i]);
         end
         step(1'b0, 1'b1);
         checks++;
         if (b_rd_ptr !== 4'(b_seq[i]) || g_rd_ptr !== gray(b_seq[i])) begin
            failures++;
            $display("FAIL wrap_ptr %0d: got b=%0d g=%0d, want b=%0d g=%0d", i, b_rd_ptr, g_rd_ptr, b_seq[i], gray(b_seq[i]));
         end
      end
      checks++;
      if (empty !== 1'b1) begin
         failures++;
         $display("FAIL wrap_empty: got %b, want 1", empty);
      end
   endtask

   task automatic test_almost_empty();
      do_reset();
      wr_cnt = 6;
      idle(3);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (rd_level !== 4'(6 - i) || almost_empty !== (i == 2)) begin
            failures++;
            $display("FAIL almost_empty at level %0d: got lvl=%0d ae=%b, want ae=%b", 6 - i, rd_level, almost_empty, i == 2);
         end
         if (i < 2) step(1'b0, 1'b1);
      end
   endtask

   task automatic test_same_cycle();
      do_reset();
      wr_cnt = 1;
      idle(3);
      wr_cnt = 2;
      idle(2);
      step(1'b0, 1'b1);
      checks++;
      if (rd_level !== 4'd1 || empty !== 1'b0 || b_rd_ptr !== 4'd1) begin
         failures++;
         $display("FAIL same_cycle: got lvl=%0d e=%b b=%0d, want lvl=1 e=0 b=1", rd_level, empty, b_rd_ptr);
      end
   endtask

   task automatic test_underflow();
      do_reset();
      step(1'b0, 1'b1);
      checks++;
      if (underflow !== UF_ON || b_rd_ptr !== 4'd0) begin
         failures++;
         $display("FAIL underflow_set: got uf=%b b=%0d, want uf=%b b=0", underflow, b_rd_ptr, UF_ON);
      end
      wr_cnt = 2;
      idle(3);
      checks++;
      if (underflow !== UF_ON || rd_level !== 4'd2) begin
         failures++;
         $display("FAIL underflow_sticky: got uf=%b lvl=%0d, want uf=%b lvl=2", underflow, rd_level, UF_ON);
      end
      step(1'b1, 1'b0);
      checks++;
      if (underflow !== 1'b0) begin
         failures++;
         $display("FAIL underflow_clear: got %b, want 0", underflow);
      end
   endtask

   task automatic test_back_to_back();
      bit rst;
      bit en;
      do_reset();
      for (int i = 0; i < 800; i++) begin
         rst = ($urandom_range(0, 99) == 0);
         en  = ($urandom_range(0, 2) != 0);
         if (rst) wr_cnt = 0;
         else if (wr_cnt - rd_cnt < DEPTH && $urandom_range(0, 1) == 1) wr_cnt++;
         step(rst, en);
         checks++;
         if (obs_fire !== pre_fire) begin
            failures++;
            $display("FAIL random_fire cycle %0d: got %b, want %b", i, obs_fire, pre_fire);
         end
         checks++;
         if ({b_rd_ptr, g_rd_ptr, rd_addr, empty, almost_empty, rd_level, underflow} !==
             {rd_cnt[PW-1:0], gray(rd_cnt), rd_cnt[PS-1:0], exp_empty, exp_ae, 4'(exp_level), exp_uf}) begin
            failures++;
            $display("FAIL random_state cycle %0d: got b=%0d g=%0d a=%0d e=%b ae=%b lvl=%0d uf=%b, want b=%0d g=%0d e=%b ae=%b lvl=%0d uf=%b",
                     i, b_rd_ptr, g_rd_ptr, rd_addr, empty, almost_empty, rd_level, underflow,
                     rd_cnt % (2 * DEPTH), gray(rd_cnt), exp_empty, exp_ae, exp_level, exp_uf);
         end
      end
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      wr_cnt    = 0;
      rd_cnt    = 0;
      exp_level = 0;
      exp_empty = 1'b1;
      exp_ae    = 1'b1;
      exp_uf    = 1'b0;
      rd_reset  = 1'b1;
      rd_en     = 1'b0;
      g_wr_ptr  = '0;
      for (int i = 0; i < SYNC; i++) hist.push_back(0);
      @(negedge rd_clk);
      test_reset();
      test_single_write();
      test_drain();
      test_wrap();
      test_almost_empty();
      test_same_cycle();
      test_underflow();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/rd_ptr_sync_ctrl.md
# rd_ptr_sync_ctrl

Read-side pointer controller for the asynchronous FIFO, generalising the existing read pointer logic. It synchronises the write-domain Gray pointer into the read clock domain through a configurable synchroniser chain and maintains the binary and Gray read pointers. From these it produces a registered empty flag, a fill level and an almost-empty flag, plus an optional sticky underflow flag. It sits between the dual-port RAM read port and the consumer, in the read clock domain only.

## Interface
- DEPTH, 128: FIFO depth in entries; power of two, minimum 4.
- PTR_SIZE, $clog2(DEPTH): address width; pointers are PTR_SIZE+1 bits.
- SYNC_STAGES, 2: flops in the write-pointer synchroniser; legal range 2 to 4.
- AE_THRESH, 4: almost-empty threshold in entries; legal range 0 to DEPTH-1.

Ports:
- rd_clk  in  1  read clock; single clock for the block.
- rd_reset  in  1  synchronous, active-high reset.
- rd_en  in  1  read request from the consumer.
- g_wr_ptr  in  PTR_SIZE+1  Gray write pointer from the write domain (asynchronous).
- rd_fire  out  1  combinational; equals rd_en & ~empty. It is the RAM read strobe.
- rd_addr  out  PTR_SIZE  RAM read address; equals b_rd_ptr[PTR_SIZE-1:0].
- b_rd_ptr  out  PTR_SIZE+1  binary read pointer (registered).
- g_rd_ptr  out  PTR_SIZE+1  Gray read pointer (registered), sent to the write domain.
- empty  out  1  registered empty flag.
- almost_empty  out  1  registered; asserted when rd_level <= AE_THRESH.
- rd_level  out  PTR_SIZE+1  registered entry count as seen from the read domain.
- underflow  out  1  sticky flag: a read was attempted while empty.

## Operation
- **Synchroniser**
  - A chain of SYNC_STAGES flops on g_wr_ptr; all stages reset to 0.
  - The last stage is Gray-to-binary converted combinationally to form wr_bin_s.
- **Pointer next-state**
  - b_next = b_rd_ptr + rd_fire, modulo 2^(PTR_SIZE+1).
  - g_next = (b_next >> 1) ^ b_next.
  - b_rd_ptr and g_rd_ptr both load from these every cycle, so g_rd_ptr always equals gray(b_rd_ptr).
- **Flags and level**, registered from next-state values:
  - empty <= (b_next == wr_bin_s).
  - rd_level <= wr_bin_s - b_next, modulo 2^(PTR_SIZE+1).
  - almost_empty <= (wr_bin_s - b_next) <= AE_THRESH.
- **Reads while empty**
  - rd_en while empty: pointers hold.
  - Feature-dependent: underflow behaviour per Configuration.
- **Wrap-around**
  - The binary pointer wraps from 2*DEPTH-1 to 0; rd_addr wraps from DEPTH-1 to 0.
  - The extra MSB preserves the full/empty distinction.
  - rd_level is a modular difference and is correct across the wrap.
- **Writer guarantee:** the synchronised distance never exceeds DEPTH, so rd_level ranges 0..DEPTH.
- **Write and read in the same cycle:** the flags use the current wr_bin_s and the post-read b_next.
  - Example: level 1, rd_fire, and a new write arriving at the synchroniser output yields level 1 and empty 0.
- **Reset values:** empty 1; almost_empty 1 (AE_THRESH >= 0); rd_level 0; all pointers 0; underflow 0.
  - Reset asserted mid-operation overrides rd_en in that cycle and clears every register, including the synchroniser stages.

## Timing
- **Write-to-visibility latency:** a g_wr_ptr change that is stable before rd_clk edge k appears in the synchroniser output after edge k+SYNC_STAGES-1.
  - empty, rd_level and almost_empty update on edge k+SYNC_STAGES, i.e. SYNC_STAGES+1 edges after sampling starts.
- **Read latency:** rd_fire sampled at edge n updates b_rd_ptr, g_rd_ptr, rd_addr and the flags at edge n.
  - When the last entry is read at edge n, empty is 1 after edge n, so no over-read is possible on back-to-back reads.
- **rd_en protocol:** may be held high continuously; one entry is consumed per cycle while empty is 0.
- **Signal timing:** rd_fire is combinational from rd_en and registered empty; no other output is combinational from an input.

## Configuration
- **Macro RD_PTR_UNDERFLOW_EN defined:**
  - underflow is set on any edge where rd_en=1 and empty=1 (reset not asserted).
  - It stays set until rd_reset. Pointers are unaffected.
- **Macro undefined:**
  - The underflow port is present and tied to constant 0.
  - No underflow register is synthesised.

## Test plan
- **Reset:** hold rd_reset 2 cycles with g_wr_ptr=0 -> empty=1, almost_empty=1, rd_level=0, b_rd_ptr=g_rd_ptr=0, underflow=0.
- **Single write, SYNC_STAGES=2:** change g_wr_ptr 0->1 before edge k -> empty falls and rd_level=1 after edge k+2, not before.
- **Drain:** with g_wr_ptr=gray(5), hold rd_en 7 cycles -> exactly 5 rd_fire pulses; rd_level 5,4,3,2,1,0; empty=1 after the 5th read; b_rd_ptr=5.
- **Wrap, DEPTH=8:** start at b_rd_ptr=14 with g_wr_ptr=gray(2), read 4 -> rd_addr sequence 6,7,0,1; b_rd_ptr 15,0,1,2; empty=1 at the end.
- **Almost-empty, AE_THRESH=4:** level 6 with reads -> almost_empty=0 at levels 6 and 5, =1 at level 4.
- **Underflow (macro defined):** rd_en=1 while empty -> underflow=1 next edge; it stays 1 after data arrives; it clears only on rd_reset. With the macro undefined it stays 0.
